pwm_moto_ctrl: RTL and testbench
================================

PWM_MOTO_CTRL -- requirements
Module: pwm_moto_ctrl

Interface
REQ-001 SHALL provide parameter CH, default 2: number of motor channels, 1..8.
REQ-002 SHALL provide parameter CW, default 8: counter/period/duty width in bits, 2..16.
REQ-003 SHALL provide parameter DEAD, default 4: dead-time cycles on direction reversal, 1..255.
REQ-004 SHALL have port sys_clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port period  input  CW  PWM period minus one (counter terminal value).
REQ-007 SHALL have port duty  input  CH*CW  per-channel high-time in cycles; channel i at bits [i*CW +: CW].
REQ-008 SHALL have port dir  input  CH  per-channel direction; 0 = drive moto_a, 1 = drive moto_b.
REQ-009 SHALL have port en  input  CH  per-channel enable.
REQ-010 SHALL have port load  input  1  one-cycle strobe capturing period/duty/dir/en into shadow registers.
REQ-011 SHALL have port load_ack  output  1  one-cycle pulse when shadow settings become active.
REQ-012 SHALL have ports moto_a, moto_b  output  CH each  per-channel H-bridge drive.
REQ-013 SHALL have port led  output  1  OR of all channel PWM signals.

Function
REQ-014 Shared counter cnt SHALL count 0..period_act, wrapping to 0 the cycle after cnt == period_act ("wrap").
REQ-015 load SHALL capture inputs into shadow and set pending; load while pending SHALL overwrite shadow, pending stays set.
REQ-016 At wrap with pending set, shadow SHALL copy into active registers, pending SHALL clear, load_ack SHALL pulse that same cycle; load and wrap in the same cycle: new inputs captured, applied at the next wrap.
REQ-017 Raw PWM for channel i SHALL be high iff en_act[i] and cnt < duty_eff[i]; duty_eff = 0 -> always low; duty_eff > period_act -> always high.
REQ-018 Outputs SHALL be registered: one cycle latency from cnt value to moto_a/moto_b/led.
REQ-019 period_act == 0 SHALL hold cnt at 0; PWM then high only where duty_eff >= 1.
REQ-020 Each channel SHALL run FSM IDLE / RUN / DEAD: IDLE both outputs low; RUN drives raw PWM on the side selected by dir_cur; DEAD both outputs low.
REQ-021 IDLE -> RUN when en_act[i] rises at wrap; RUN -> IDLE when en_act[i] falls; DEAD -> IDLE if en_act[i] falls during DEAD.
REQ-022 RUN with dir_act[i] != dir_cur[i] after a wrap SHALL enter DEAD for exactly DEAD cycles, then update dir_cur[i] and return to RUN.
REQ-023 Direction changes applied while IDLE SHALL update dir_cur[i] immediately, without DEAD.
REQ-024 moto_a[i] and moto_b[i] SHALL never be high in the same cycle under any input sequence.
REQ-025 A DEAD interval SHALL not be shortened or restarted by further loads; the latest dir_act is used on exit.

Reset
REQ-026 With sys_rst_n low at a rising edge: cnt, active and shadow registers, pending, duty_eff, dir_cur = 0; all FSMs IDLE; moto_a, moto_b, led, load_ack = 0 the following cycle.
REQ-027 Reset asserted mid-period or mid-DEAD SHALL abort immediately; after release, no output until a load and wrap occur.

Configuration
REQ-028 Macro PWM_MOTO_RAMP_EN defined: at each wrap, duty_eff[i] SHALL step by 1 toward duty_act[i] (up or down), saturating at target; entering IDLE or DEAD SHALL reset duty_eff[i] to 0.
REQ-029 Macro PWM_MOTO_RAMP_EN undefined: duty_eff[i] SHALL equal duty_act[i] directly; no ramp logic is synthesised.

Verification
REQ-030 CH=2, CW=8, period=9, duty0=3, en=01, dir=00, load -> load_ack at first wrap; moto_a[0] high 3 of every 10 cycles; moto_b = 0; led follows moto_a[0].
REQ-031 Running ch0 dir 0, load dir=1 mid-period -> at wrap both outputs low exactly DEAD=4 cycles, then moto_b[0] PWM; never a===b===1.
REQ-032 duty=0 -> outputs stay low; duty=10 with period=9 -> moto_a constant high; period=0, duty=1 -> constant high, cnt stuck at 0.
REQ-033 Two loads before a wrap (duty 2 then 6) -> single load_ack, duty 6 applied; load coincident with wrap -> applied one period later.
REQ-034 Reset pulsed mid-DEAD -> all outputs 0 next cycle, FSM IDLE, no output after release until load + wrap.
REQ-035 PWM_MOTO_RAMP_EN defined, duty 0 -> 5, period=9 -> high time 1,2,3,4,5 over five successive periods, then constant 5.

Source files
------------

// File: rtl/pwm_moto_ctrl.sv
// pwm_moto_ctrl: multi-channel PWM H-bridge motor controller.
//
// One shared period counter drives CH PWM comparators. New period, duty,
// direction and enable settings are captured into shadow registers on a
// load strobe. They become active only at the next counter wrap, so a
// PWM period is never cut short by a settings change. Each channel has an
// IDLE/RUN/DEAD state machine. On a direction reversal it inserts DEAD
// cycles of "both sides off", so the two halves of the bridge are never
// driven together.
//
// Optional feature macro: PWM_MOTO_RAMP_EN
//   defined   - the effective duty steps by one count per period toward the
//               programmed duty (soft start / soft stop). It restarts from
//               zero whenever a channel leaves RUN.
//   undefined - the effective duty is the programmed duty (no ramp logic).

module pwm_moto_ctrl #(
  parameter int CH   = 2,
  parameter int CW   = 8,
  parameter int DEAD = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic [CH-1:0]    dir,
  input  logic [CH-1:0]    en,
  input  logic             load,
  output logic             load_ack,
  output logic [CH-1:0]    moto_a,
  output logic [CH-1:0]    moto_b,
  output logic             led
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // Dead-time counter start value; the counter runs DEAD-1 down to 0.
  localparam logic [7:0] DEAD_LAST = 8'(DEAD - 1);

  // Shared counter and the wrap / apply events derived from it.
  logic [CW-1:0]    cnt;
  logic             wrap;
  logic             apply;

  // Shadow (software-visible) and active (in-use) settings.
  logic [CW-1:0]    period_sh;
  logic [CH*CW-1:0] duty_sh;
  logic [CH-1:0]    dir_sh;
  logic [CH-1:0]    en_sh;
  logic             pending;

  logic [CW-1:0]    period_act;
  logic [CH*CW-1:0] duty_act;
  logic [CH-1:0]    dir_act;
  logic [CH-1:0]    en_act;

  // The active settings as they will be after the current clock edge.
  // The FSMs look at these so a channel changes state on the same edge
  // that the new settings take effect.
  logic [CH-1:0]    dir_new;
  logic [CH-1:0]    en_new;

  // Duty value that the comparators actually use.
  logic [CH*CW-1:0] duty_eff;

  // Per-channel state machine registers.
  state_t           state_q [CH];
  state_t           state_d [CH];
  logic [7:0]       dead_q  [CH];
  logic [7:0]       dead_d  [CH];
  logic [CH-1:0]    dir_cur_q;
  logic [CH-1:0]    dir_cur_d;

  // Combinational PWM and drive values ahead of the output registers.
  logic [CH-1:0]    pwm_raw;
  logic [CH-1:0]    drive_a;
  logic [CH-1:0]    drive_b;

  assign wrap    = (cnt == period_act);
  assign apply   = wrap & pending;
  assign dir_new = apply ? dir_sh : dir_act;
  assign en_new  = apply ? en_sh  : en_act;

  // Shared period counter: counts 0..period_act. A period of zero keeps it at 0.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow capture on load. A later load overwrites an earlier one that has not been applied yet.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      period_sh <= '0;
      duty_sh   <= '0;
      dir_sh    <= '0;
      en_sh     <= '0;
    end else if (load) begin
      period_sh <= period;
      duty_sh   <= duty;
      dir_sh    <= dir;
      en_sh     <= en;
    end
  end

  // Pending flag: set by load, cleared at the wrap that applies it. A load coincident with wrap stays pending.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pending <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
    end else if (wrap) begin
      pending <= 1'b0;
    end
  end

  // Shadow-to-active transfer at wrap, with a one-cycle acknowledge pulse.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      period_act <= '0;
      duty_act   <= '0;
      dir_act    <= '0;
      en_act     <= '0;
      load_ack   <= 1'b0;
    end else begin
      load_ack <= apply;
      if (apply) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
        dir_act    <= dir_sh;
        en_act     <= en_sh;
      end
    end
  end

  // Per-channel state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dir_cur_q <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        dead_q[i]  <= '0;
      end
    end else begin
      dir_cur_q <= dir_cur_d;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        dead_q[i]  <= dead_d[i];
      end
    end
  end

  // Per-channel next-state logic. A reversal in RUN goes through DEAD. In DEAD the
  // direction is not re-examined until the interval ends, so further loads can
  // neither shorten nor restart it.
  always_comb begin
    dir_cur_d = dir_cur_q;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      dead_d[i]  = dead_q[i];
      case (state_q[i])
        ST_IDLE: begin
          dir_cur_d[i] = dir_new[i];
          if (wrap && en_new[i]) begin
            state_d[i] = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en_new[i]) begin
            state_d[i] = ST_IDLE;
          end else if (dir_new[i] != dir_cur_q[i]) begin
            state_d[i] = ST_DEAD;
            dead_d[i]  = DEAD_LAST;
          end
        end
        ST_DEAD: begin
          if (!en_new[i]) begin
            state_d[i] = ST_IDLE;
          end else if (dead_q[i] == 8'd0) begin
            state_d[i]   = ST_RUN;
            dir_cur_d[i] = dir_new[i];
          end else begin
            dead_d[i] = dead_q[i] - 8'd1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

`ifdef PWM_MOTO_RAMP_EN
  logic [CH*CW-1:0] duty_new;
  logic [CH*CW-1:0] duty_eff_q;
  logic [CH*CW-1:0] duty_eff_d;

  assign duty_new = apply ? duty_sh : duty_act;
  assign duty_eff = duty_eff_q;

  // Ramp step: one count per wrap toward the target. The value is forced to zero outside RUN.
  always_comb begin
    duty_eff_d = duty_eff_q;
    for (int i = 0; i < CH; i++) begin
      if (state_d[i] != ST_RUN) begin
        duty_eff_d[i*CW +: CW] = '0;
      end else if (wrap) begin
        if (duty_eff_q[i*CW +: CW] < duty_new[i*CW +: CW]) begin
          duty_eff_d[i*CW +: CW] = duty_eff_q[i*CW +: CW] + CW'(1);
        end else if (duty_eff_q[i*CW +: CW] > duty_new[i*CW +: CW]) begin
          duty_eff_d[i*CW +: CW] = duty_eff_q[i*CW +: CW] - CW'(1);
        end
      end
    end
  end

  // Ramp register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      duty_eff_q <= '0;
    end else begin
      duty_eff_q <= duty_eff_d;
    end
  end
`else
  assign duty_eff = duty_act;
`endif

  // PWM comparators and side selection. Only RUN drives, and only on the dir_cur side,
  // so a and b can never both be high.
  always_comb begin
    pwm_raw = '0;
    drive_a = '0;
    drive_b = '0;
    for (int i = 0; i < CH; i++) begin
      pwm_raw[i] = en_act[i] && (cnt < duty_eff[i*CW +: CW]);
      if (state_q[i] == ST_RUN) begin
        drive_a[i] = pwm_raw[i] & ~dir_cur_q[i];
        drive_b[i] = pwm_raw[i] &  dir_cur_q[i];
      end
    end
  end

  // Registered bridge drive and activity LED.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      moto_a <= '0;
      moto_b <= '0;
      led    <= 1'b0;
    end else begin
      moto_a <= drive_a;
      moto_b <= drive_b;
      led    <= |(drive_a | drive_b);
    end
  end

endmodule

// File: tb/tb_pwm_moto_ctrl.sv
// Testbench for pwm_moto_ctrl (CH=2, CW=8, DEAD=4).
// Also covers the PWM_MOTO_RAMP_EN build when that macro is defined.

module tb_pwm_moto_ctrl;

  localparam int CH   = 2;
  localparam int CW   = 8;
  localparam int DEAD = 4;

`ifdef PWM_MOTO_RAMP_EN
  localparam int FIRST_HIGH = 1;
`else
  localparam int FIRST_HIGH = 3;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [CW-1:0]    period = '0;
  logic [CH*CW-1:0] duty = '0;
  logic [CH-1:0]    dir = '0;
  logic [CH-1:0]    en = '0;
  logic             load = 1'b0;
  logic             load_ack;
  logic [CH-1:0]    moto_a;
  logic [CH-1:0]    moto_b;
  logic             led;

  int vectors = 0;
  int miscompares = 0;
  int overlap = 0;

  typedef struct {
    int         per;
    int         d0;
    int         d1;
    logic [1:0] en;
    logic [1:0] dir;
    int         a0;
    int         b0;
    int         a1;
    int         b1;
    int         ld;
  } vec_t;

  vec_t vecs [8];

  pwm_moto_ctrl #(.CH(CH), .CW(CW), .DEAD(DEAD)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .period    (period),
    .duty      (duty),
    .dir       (dir),
    .en        (en),
    .load      (load),
    .load_ack  (load_ack),
    .moto_a    (moto_a),
    .moto_b    (moto_b),
    .led       (led)
  );

  always #5 sys_clk = ~sys_clk;

  // Watch every cycle for both bridge sides high on any channel.
  always @(negedge sys_clk) begin
    if (|(moto_a & moto_b)) overlap++;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge: drive settings with a one-cycle load strobe.
  task automatic applyStimulus(input int per, input int d0, input int d1,
                               input logic [1:0] e, input logic [1:0] dr);
    period = CW'(per);
    duty   = {CW'(d1), CW'(d0)};
    en     = e;
    dir    = dr;
    load   = 1'b1;
    @(negedge sys_clk);
    load   = 1'b0;
  endtask

  task automatic waitAck(input int budget, output int found);
    found = 0;
    for (int k = 0; k < budget && found == 0; k++) begin
      @(negedge sys_clk);
      if (load_ack) found = 1;
    end
  endtask

  task automatic measure(input int cycles, output int a0, output int b0,
                         output int a1, output int b1, output int ld);
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; ld = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge sys_clk);
      a0 += int'(moto_a[0]);
      b0 += int'(moto_b[0]);
      a1 += int'(moto_a[1]);
      b1 += int'(moto_b[1]);
      ld += int'(led);
    end
  endtask

  initial begin
    int a0, b0, a1, b1, ld, found, n, g, t, bad, acks;

    //          per d0  d1  en     dir    a0  b0  a1  b1  led   (highs per period)
    vecs[0] = '{9,  3,  0,  2'b01, 2'b00, 3,  0,  0,  0,  3};
    vecs[1] = '{9,  3,  5,  2'b11, 2'b10, 3,  0,  0,  5,  5};
    vecs[2] = '{9,  0,  5,  2'b11, 2'b00, 0,  0,  5,  0,  5};
    vecs[3] = '{9,  10, 0,  2'b01, 2'b00, 10, 0,  0,  0,  10};
    vecs[4] = '{9,  9,  15, 2'b11, 2'b01, 0,  9,  10, 0,  10};
    vecs[5] = '{0,  1,  0,  2'b11, 2'b00, 1,  0,  0,  0,  1};
    vecs[6] = '{4,  2,  4,  2'b10, 2'b00, 0,  0,  4,  0,  4};
    vecs[7] = '{7,  3,  3,  2'b00, 2'b00, 0,  0,  0,  0,  0};

    // Reset state.
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset moto_a", int'(moto_a), 0);
    checkOutput("reset moto_b", int'(moto_b), 0);
    checkOutput("reset led", int'(led), 0);
    checkOutput("reset load_ack", int'(load_ack), 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // First load after reset: the active period is 0, so the next cycle is a wrap.
    period = CW'(9); duty = {CW'(0), CW'(3)}; en = 2'b01; dir = 2'b00; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    checkOutput("ack not before wrap", int'(load_ack), 0);
    @(negedge sys_clk);
    checkOutput("ack at first wrap", int'(load_ack), 1);
    bad = 0; acks = 0; a0 = 0; b0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      a0 += int'(moto_a[0]);
      b0 += int'(moto_b[0]);
      if (led != moto_a[0]) bad++;
      acks += int'(load_ack);
    end
    checkOutput("first period a0 highs", a0, FIRST_HIGH);
    checkOutput("first period b0 highs", b0, 0);
    checkOutput("led follows a0", bad, 0);
    checkOutput("ack single pulse", acks, 0);

    // Table of steady-state patterns, measured over two full periods.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].per, vecs[i].d0, vecs[i].d1, vecs[i].en, vecs[i].dir);
      waitAck(300, found);
      checkOutput($sformatf("vec%0d ack", i), found, 1);
      repeat (40 * (vecs[i].per + 1)) @(negedge sys_clk);
      measure(2 * (vecs[i].per + 1), a0, b0, a1, b1, ld);
      checkOutput($sformatf("vec%0d a0", i), a0, 2 * vecs[i].a0);
      checkOutput($sformatf("vec%0d b0", i), b0, 2 * vecs[i].b0);
      checkOutput($sformatf("vec%0d a1", i), a1, 2 * vecs[i].a1);
      checkOutput($sformatf("vec%0d b1", i), b1, 2 * vecs[i].b1);
      checkOutput($sformatf("vec%0d led", i), ld, 2 * vecs[i].ld);
      if (vecs[i].per == 0) begin
        checkOutput($sformatf("vec%0d cnt stuck", i), int'(dut.cnt), 0);
      end
    end

`ifndef PWM_MOTO_RAMP_EN
    // Direction reversal while running: exactly DEAD cycles with both sides off.
    applyStimulus(9, 10, 0, 2'b01, 2'b00);
    waitAck(300, found);
    checkOutput("dead setup ack", found, 1);
    repeat (33) @(negedge sys_clk);
    checkOutput("dead setup a0 high", int'(moto_a[0]), 1);
    applyStimulus(9, 10, 0, 2'b01, 2'b01);
    t = 0;
    while (moto_a[0] && t < 40) begin
      @(negedge sys_clk);
      t++;
    end
    checkOutput("a0 falls after reversal", int'(t < 40), 1);
    g = 0;
    while (!moto_b[0] && g < 40) begin
      g++;
      @(negedge sys_clk);
    end
    checkOutput("dead gap length", g, DEAD);
    measure(20, a0, b0, a1, b1, ld);
    checkOutput("b0 high after dead", b0, 20);
    checkOutput("a0 low after dead", a0, 0);
`endif

    // Two loads in one period: one acknowledge, the later duty wins.
    applyStimulus(9, 4, 0, 2'b01, 2'b00);
    waitAck(300, found);
    checkOutput("double load setup ack", found, 1);
    repeat (2) @(negedge sys_clk);
    applyStimulus(9, 2, 0, 2'b01, 2'b00);
    @(negedge sys_clk);
    applyStimulus(9, 6, 0, 2'b01, 2'b00);
    acks = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge sys_clk);
      acks += int'(load_ack);
    end
    checkOutput("double load ack count", acks, 1);
    repeat (400) @(negedge sys_clk);
    measure(10, a0, b0, a1, b1, ld);
    checkOutput("double load duty", a0, 6);

    // Load coincident with wrap: applied one full period later.
    applyStimulus(9, 5, 0, 2'b01, 2'b00);
    waitAck(300, found);
    checkOutput("coincident setup ack", found, 1);
    repeat (9) @(negedge sys_clk);
    applyStimulus(9, 7, 0, 2'b01, 2'b00);
    checkOutput("no ack at coincident wrap", int'(load_ack), 0);
    n = 1;
    while (!load_ack && n < 30) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("coincident load latency", n, 11);

    // Reset in the middle of a dead-time interval.
    applyStimulus(9, 10, 0, 2'b01, 2'b01);
    waitAck(300, found);
    checkOutput("reset-dead setup ack", found, 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checkOutput("reset mid-dead outputs", int'({moto_a, moto_b, led, load_ack}), 0);
    sys_rst_n = 1'b1;
    measure(40, a0, b0, a1, b1, ld);
    checkOutput("silent after reset", a0 + b0 + a1 + b1 + ld, 0);
    applyStimulus(9, 3, 0, 2'b01, 2'b01);
    waitAck(300, found);
    checkOutput("post-reset ack", found, 1);
    repeat (400) @(negedge sys_clk);
    measure(10, a0, b0, a1, b1, ld);
    checkOutput("post-reset b0", b0, 3);
    checkOutput("post-reset a0", a0, 0);

`ifdef PWM_MOTO_RAMP_EN
    // Soft start from reset: 1,2,3,4,5 then constant 5.
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    applyStimulus(9, 5, 0, 2'b01, 2'b00);
    waitAck(300, found);
    checkOutput("ramp ack", found, 1);
    for (int p = 0; p < 6; p++) begin
      measure(10, a0, b0, a1, b1, ld);
      checkOutput($sformatf("ramp period %0d", p), a0, (p < 5) ? p + 1 : 5);
    end
`endif

    checkOutput("no a/b overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
